// File: rtl/xport_pkg.sv
// Shared widths for the CPU-writable transport registers and their consumers.
package xport_pkg;
    localparam int PWM_WIDTH    = 16;
    localparam int PWM_PS_WIDTH = 8;
endpackage

// File: rtl/sync_stable16.sv
// Captures a bus-written register value into the clock domain.
// The value is taken only after two consecutive samples agree, so that a
// multi-bit value caught while it is changing can never reach the output.
module sync_stable16
    import xport_pkg::*;
#(
    parameter int W = PWM_WIDTH
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [W-1:0] In,
    output logic [W-1:0] Out
);

    logic [W-1:0] syncA;
    logic [W-1:0] syncB;

    // Two-stage sample, then update the stable copy only when both stages match.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            syncA <= '0;
            syncB <= '0;
            Out   <= '0;
        end else begin
            syncA <= In;
            syncB <= syncA;
            if (syncA == syncB) begin
                Out <= syncB;
            end
        end
    end

endmodule

// File: rtl/pwm_gen16.sv
// Single-channel PWM generator.
// Period and duty are captured through stability filters, held in shadow
// registers, and only reloaded into the shadows at a counter wrap so a pulse
// never changes width partway through a cycle.
module pwm_gen16
    import xport_pkg::*;
#(
    parameter int WIDTH    = PWM_WIDTH,
    parameter int PS_WIDTH = PWM_PS_WIDTH
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Enable,
    input  logic [WIDTH-1:0]    Period,
    input  logic [WIDTH-1:0]    Duty,
    input  logic [PS_WIDTH-1:0] Prescale,
    input  logic                Polarity,
    output logic                PwmOut,
    output logic                PeriodTick,
    output logic [WIDTH-1:0]    Count
);

    logic [WIDTH-1:0]    stablePeriod;
    logic [WIDTH-1:0]    stableDuty;
    logic [WIDTH-1:0]    shPeriod;
    logic [WIDTH-1:0]    shDuty;
    logic [PS_WIDTH-1:0] psCnt;
    logic                tick;
    logic                wrap;

    sync_stable16 #(.W(WIDTH)) uSyncPeriod (
        .Clk   (Clk),
        .Reset (Reset),
        .In    (Period),
        .Out   (stablePeriod)
    );

    sync_stable16 #(.W(WIDTH)) uSyncDuty (
        .Clk   (Clk),
        .Reset (Reset),
        .In    (Duty),
        .Out   (stableDuty)
    );

    // Lowering Prescale below psCnt simply lets psCnt run round through all ones.
    assign tick = Enable && (psCnt == Prescale);
    assign wrap = tick && (Count >= shPeriod);

    // Prescaler: counts clocks up to Prescale, then restarts with a tick.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            psCnt <= '0;
        end else if (!Enable || tick) begin
            psCnt <= '0;
        end else begin
            psCnt <= psCnt + 1'b1;
        end
    end

    // Period counter and shadow reload; shadows follow the inputs while idle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Count      <= '0;
            PeriodTick <= 1'b0;
            shPeriod   <= '0;
            shDuty     <= '0;
        end else if (!Enable) begin
            Count      <= '0;
            PeriodTick <= 1'b0;
            shPeriod   <= stablePeriod;
            shDuty     <= stableDuty;
        end else begin
            PeriodTick <= wrap;
            if (wrap) begin
                Count    <= '0;
                shPeriod <= stablePeriod;
                shDuty   <= stableDuty;
            end else if (tick) begin
                Count <= Count + 1'b1;
            end
        end
    end

    // Registered output; polarity applies immediately, not at a boundary.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            PwmOut <= 1'b0;
        end else if (!Enable) begin
            PwmOut <= Polarity;
        end else begin
            PwmOut <= (Count < shDuty) ^ Polarity;
        end
    end

endmodule
